// File: rtl/weight_dma_nbank.sv
// weight_dma_nbank: streams conv then FC weights from a linear source
// into one conv bank and NB word-interleaved FC banks.
module weight_dma_nbank #(
    parameter int DW  = 16,
    parameter int AW  = 16,
    parameter int NB  = 4,
    parameter int BAW = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic           i_abort,
    input  logic [AW-1:0]  i_src_base,
    input  logic [AW-1:0]  i_conv_len,
    input  logic [AW-1:0]  i_fc_len,
    output logic           o_src_rd,
    output logic [AW-1:0]  o_src_addr,
    input  logic [DW-1:0]  i_src_data,
    output logic           o_conv_we,
    output logic [NB-1:0]  o_fc_we,
    output logic [DW-1:0]  o_wdata,
    output logic [BAW-1:0] o_wr_addr,
    output logic           o_busy,
    output logic           o_conv_done,
    output logic           o_done,
    output logic           o_err
);

    localparam int LNB = $clog2(NB);
    localparam int unsigned DEPTH = 32'd1 << BAW;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [2:0] {IDLE, CONV, FC, DRAIN, DONE} state_t;

    state_t        state;
    logic [AW-1:0] conv_len_q;
    logic [AW-1:0] fc_len_q;
    logic [AW-1:0] idx;
    logic          conv_wlast;
    logic          cfg_bad;
    logic          last_rd;
    logic [NB-1:0] fc_sel;

    assign o_wdata = i_src_data;

    always_comb begin
        cfg_bad = (32'(i_conv_len) > DEPTH) ||
                  (((32'(i_fc_len) + 32'(NB - 1)) >> LNB) > DEPTH);
        last_rd = 1'b0;
        if (state == CONV)
            last_rd = (idx == conv_len_q - ONE);
        else if (state == FC)
            last_rd = (idx == fc_len_q - ONE);
        fc_sel = '0;
        fc_sel[idx[LNB-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            conv_len_q  <= '0;
            fc_len_q    <= '0;
            idx         <= '0;
            conv_wlast  <= 1'b0;
            o_src_rd    <= 1'b0;
            o_src_addr  <= '0;
            o_conv_we   <= 1'b0;
            o_fc_we     <= '0;
            o_wr_addr   <= '0;
            o_busy      <= 1'b0;
            o_conv_done <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_conv_we <= 1'b0;
            o_fc_we   <= '0;
            unique case (state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        conv_len_q  <= i_conv_len;
                        fc_len_q    <= i_fc_len;
                        o_src_addr  <= i_src_base;
                        idx         <= '0;
                        o_conv_done <= 1'b0;
                        o_err       <= cfg_bad;
                        if (!cfg_bad) begin
                            if (i_conv_len != '0) begin
                                state    <= CONV;
                                o_src_rd <= 1'b1;
                                o_busy   <= 1'b1;
                            end else begin
                                o_conv_done <= 1'b1;
                                if (i_fc_len != '0) begin
                                    state    <= FC;
                                    o_src_rd <= 1'b1;
                                    o_busy   <= 1'b1;
                                end else begin
                                    state  <= DONE;
                                    o_done <= 1'b1;
                                end
                            end
                        end
                    end
                end
                CONV, FC: begin
                    if (i_abort) begin
                        state    <= IDLE;
                        o_src_rd <= 1'b0;
                        o_busy   <= 1'b0;
                    end else begin
                        if (o_conv_we && conv_wlast)
                            o_conv_done <= 1'b1;
                        o_src_addr <= o_src_addr + ONE;
                        idx        <= idx + ONE;
                        // write side trails the read by one cycle
                        if (state == CONV) begin
                            o_conv_we  <= 1'b1;
                            o_wr_addr  <= BAW'(idx);
                            conv_wlast <= last_rd;
                        end else begin
                            o_fc_we   <= fc_sel;
                            o_wr_addr <= BAW'(idx >> LNB);
                        end
                        if (last_rd) begin
                            if (state == CONV && fc_len_q != '0) begin
                                state <= FC;
                                idx   <= '0;
                            end else begin
                                state    <= DRAIN;
                                o_src_rd <= 1'b0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    o_busy <= 1'b0;
                    if (i_abort) begin
                        state <= IDLE;
                    end else begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        if (o_conv_we && conv_wlast)
                            o_conv_done <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_dma_nbank.sv
// Bench for weight_dma_nbank: directed table rows plus random
// transfers compared cycle by cycle with a timing-rule model.
module tb_weight_dma_nbank;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int NB  = 4;
    localparam int BAW = 11;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic           i_abort = 1'b0;
    logic [AW-1:0]  i_src_base = '0;
    logic [AW-1:0]  i_conv_len = '0;
    logic [AW-1:0]  i_fc_len = '0;
    logic           o_src_rd;
    logic [AW-1:0]  o_src_addr;
    logic [DW-1:0]  i_src_data = '0;
    logic           o_conv_we;
    logic [NB-1:0]  o_fc_we;
    logic [DW-1:0]  o_wdata;
    logic [BAW-1:0] o_wr_addr;
    logic           o_busy;
    logic           o_conv_done;
    logic           o_done;
    logic           o_err;

    always #5 clk = ~clk;

    weight_dma_nbank #(.DW(DW), .AW(AW), .NB(NB), .BAW(BAW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_src_base(i_src_base), .i_conv_len(i_conv_len),
        .i_fc_len(i_fc_len), .o_src_rd(o_src_rd), .o_src_addr(o_src_addr),
        .i_src_data(i_src_data), .o_conv_we(o_conv_we), .o_fc_we(o_fc_we),
        .o_wdata(o_wdata), .o_wr_addr(o_wr_addr), .o_busy(o_busy),
        .o_conv_done(o_conv_done), .o_done(o_done), .o_err(o_err)
    );

    typedef struct packed {
        logic           rd;
        logic [AW-1:0]  addr;
        logic           cwe;
        logic [NB-1:0]  fwe;
        logic [BAW-1:0] waddr;
        logic           busy;
        logic           cdone;
        logic           done;
        logic           err;
        logic [DW-1:0]  wdata;
    } obs_t;

    typedef struct {
        logic [AW-1:0] base;
        int conv;
        int fc;
        int abort_c;
        int stray_c;
        int rst_c;
        int exp_done;
        int exp_cdone;
        int exp_cw;
        int exp_bank[NB];
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[10];

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_bits(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [AW-1:0] base, input int conv,
                                input int fc, input int ab, input int st,
                                input int rs, input int dn, input int cd,
                                input int cw, input int b0, input int b1,
                                input int b2, input int b3);
        vec_t v;
        v.base = base; v.conv = conv; v.fc = fc;
        v.abort_c = ab; v.stray_c = st; v.rst_c = rs;
        v.exp_done = dn; v.exp_cdone = cd; v.exp_cw = cw;
        v.exp_bank[0] = b0; v.exp_bank[1] = b1;
        v.exp_bank[2] = b2; v.exp_bank[3] = b3;
        return v;
    endfunction

    function automatic bit is_bad(input vec_t v);
        return (v.conv > (1 << BAW)) || ((v.fc + NB - 1) / NB > (1 << BAW));
    endfunction

    // Expected outputs in cycle c after a start sampled at edge 0.
    function automatic obs_t model(input int c, input vec_t v);
        obs_t o;
        int L, cc, n, k;
        o = '0;
        o.wdata = i_src_data;
        L = v.conv + v.fc;
        if (v.rst_c > 0 && c > v.rst_c) return o;
        if (is_bad(v)) begin
            o.err = 1'b1;
            return o;
        end
        cc = c;
        if (v.abort_c > 0 && c > v.abort_c) begin
            cc = v.abort_c;
        end else begin
            if (c <= L) begin
                o.rd = 1'b1;
                o.addr = AW'(int'(v.base) + c - 1);
            end
            if (c >= 2 && c <= L + 1) begin
                n = c - 2;
                if (n < v.conv) begin
                    o.cwe = 1'b1;
                    o.waddr = BAW'(n);
                end else begin
                    k = n - v.conv;
                    o.fwe[k % NB] = 1'b1;
                    o.waddr = BAW'(k / NB);
                end
            end
            o.busy = (L > 0) && (c <= L + 1);
            o.done = (L == 0) ? (c == 1) : (c == L + 2);
        end
        o.cdone = (v.conv == 0) || (cc >= v.conv + 2);
        return o;
    endfunction

    function automatic obs_t observe(input obs_t e);
        obs_t a;
        a.rd    = o_src_rd;
        a.addr  = e.rd ? o_src_addr : '0;
        a.cwe   = o_conv_we;
        a.fwe   = o_fc_we;
        a.waddr = (e.cwe || (|e.fwe)) ? o_wr_addr : '0;
        a.busy  = o_busy;
        a.cdone = o_conv_done;
        a.done  = o_done;
        a.err   = o_err;
        a.wdata = o_wdata;
        return a;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({o_src_rd, o_src_addr, o_conv_we, o_fc_we, o_wr_addr,
                    o_busy, o_conv_done, o_done, o_err});
    endfunction

    task automatic run(input vec_t v, input string tag, input bit summ);
        obs_t e, a;
        int lim, fdone, fcd, ncw, L;
        int nb[NB];
        L = v.conv + v.fc;
        fdone = -1; fcd = -1; ncw = 0;
        for (int b = 0; b < NB; b++) nb[b] = 0;
        if (v.rst_c > 0) lim = v.rst_c + 2;
        else if (is_bad(v)) lim = 3;
        else lim = L + 3;
        i_src_base = v.base;
        i_conv_len = AW'(v.conv);
        i_fc_len = AW'(v.fc);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 1; c <= lim; c++) begin
            e = model(c, v);
            a = observe(e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, c, a, e);
            end
            if (o_done && fdone < 0) fdone = c;
            if (o_conv_done && fcd < 0) fcd = c;
            if (o_conv_we) ncw++;
            for (int b = 0; b < NB; b++) if (o_fc_we[b]) nb[b]++;
            i_src_data = DW'($urandom);
            i_abort = (c == v.abort_c);
            if (c == v.stray_c) begin
                i_start = 1'b1;
                i_src_base = ~v.base;
                i_conv_len = 16'd5;
                i_fc_len = 16'd7;
            end else begin
                i_start = 1'b0;
            end
            if (c == v.rst_c) begin
                rst_n = 1'b0;
                #1;
                chk_bits({tag, " reset_now"}, all_outs(), 64'd0);
                #1;
                rst_n = 1'b1;
            end
            @(negedge clk);
        end
        i_abort = 1'b0;
        i_start = 1'b0;
        if (summ) begin
            chk_int({tag, " done_cycle"}, fdone, v.exp_done);
            chk_int({tag, " conv_done_cycle"}, fcd, v.exp_cdone);
            chk_int({tag, " conv_writes"}, ncw, v.exp_cw);
            for (int b = 0; b < NB; b++)
                chk_int($sformatf("%s bank%0d_writes", tag, b), nb[b],
                        v.exp_bank[b]);
        end
    endtask

    initial begin
        vec_t rv;
        int L;
        tbl[0] = mk(16'h0100, 162, 1296, 0, 0, 0, 1460, 164, 162,
                    324, 324, 324, 324);
        tbl[1] = mk(16'h0200, 0, 6, 0, 0, 0, 8, 1, 0, 2, 2, 1, 1);
        tbl[2] = mk(16'h0300, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[3] = mk(16'h0400, 2049, 4, 0, 0, 0, -1, -1, 0, 0, 0, 0, 0);
        tbl[4] = mk(16'hFFFE, 3, 5, 0, 0, 0, 10, 5, 3, 2, 1, 1, 1);
        tbl[5] = mk(16'h0100, 162, 1296, 50, 20, 0, -1, -1, 49,
                    0, 0, 0, 0);
        tbl[6] = mk(16'h0100, 162, 1296, 0, 0, 30, -1, -1, 29,
                    0, 0, 0, 0);
        tbl[7] = mk(16'h0100, 5, 9, 0, 0, 0, 16, 7, 5, 3, 2, 2, 2);
        tbl[8] = mk(16'h0500, 0, 8193, 0, 0, 0, -1, -1, 0, 0, 0, 0, 0);
        tbl[9] = mk(16'h8000, 2048, 8192, 0, 0, 0, 10242, 2050, 2048,
                    2048, 2048, 2048, 2048);

        repeat (3) @(negedge clk);
        chk_bits("reset_state", all_outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run(tbl[i], $sformatf("row%0d", i), 1'b1);

        // start and abort together in IDLE: abort wins
        i_src_base = 16'h0700;
        i_conv_len = 16'd3;
        i_fc_len = 16'd0;
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        chk_bits("start_abort_c1",
                 64'({o_src_rd, o_busy, o_done, o_conv_done, o_err}),
                 64'(5'b00010));
        @(negedge clk);
        chk_bits("start_abort_c2",
                 64'({o_src_rd, o_busy, o_done, o_conv_done, o_err}),
                 64'(5'b00010));

        for (int r = 0; r < 30; r++) begin
            rv = mk(AW'($urandom), int'($urandom_range(0, 30)),
                    int'($urandom_range(0, 30)), 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0);
            L = rv.conv + rv.fc;
            if (L > 0 && $urandom_range(0, 2) == 0)
                rv.abort_c = int'($urandom_range(1, L + 1));
            run(rv, $sformatf("rnd%0d", r), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
